mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Parametrised MEM pipeline stage for the MIPS core. It replaces the pure pass-through stage with real load/store execution: it issues byte, halfword and word accesses on a single-outstanding req/ack data bus, and it extends and aligns load data. Stalls are requested from pipeline control while a transaction is pending. The MEM/WB register is folded in, so every WB-facing output is registered.

Parameters:
ADDR_W, 32, data-bus address width
REG_ADDR_W, 5, register-file address width
TIMEOUT_CYC, 255, cycles in WAIT without ack before bus error; 0 disables the timeout
BIG_ENDIAN, 1, byte-lane ordering: 1 = MIPS big-endian, 0 = little-endian

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  discard the current/pending op result
ex_valid  in  1  EX presents an op
ex_wd  in  REG_ADDR_W  destination register
ex_wreg  in  1  register write enable
ex_wdata  in  32  ALU result (non-memory ops)
ex_memop  in  4  0=NONE,1=LB,2=LBU,3=LH,4=LHU,5=LW,6=SB,7=SH,8=SW; others are treated as NONE
ex_addr  in  ADDR_W  effective address
ex_sdata  in  32  store data, right-justified
stall_req  out  1  combinational; EX must hold ex_* stable while high
mem_req  out  1  bus request (registered)
mem_we  out  1  write
mem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
mem_sel  out  4  byte-lane enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  transaction complete; rdata valid in the same cycle
mem_rdata  in  32  read data
wb_valid  out  1  WB entry valid
wb_wd  out  REG_ADDR_W  destination
wb_wreg  out  1  write enable
wb_wdata  out  32  write data
exc_align  out  1  one-cycle pulse, misaligned access
exc_buserr  out  1  one-cycle pulse, bus timeout

Behaviour:
- Reset: state=IDLE; all registered outputs 0. This gives wb_wd=NOP reg 0, mem_addr=0 and mem_sel=0. Reset mid-transaction drops mem_req the next cycle with no WB write.
- IDLE, ex_valid with NONE: wb_* <= ex_* with wb_valid=1 on the next edge, i.e. 1-cycle latency. stall_req=0.
- IDLE, ex_valid with a memory op, misaligned (halfword addr[0]=1, word addr[1:0]!=0):
  - no bus request;
  - exc_align pulses;
  - wb_valid=1, wb_wreg=0.
- IDLE, ex_valid with an aligned memory op:
  - stall_req=1;
  - on the edge: mem_req<=1 with we/addr/sel/wdata, wb_valid<=0, state<=WAIT, timer<=0.
- WAIT: mem_req and all mem_* are held stable until mem_ack. stall_req=!mem_ack.
- On mem_ack in WAIT:
  - mem_req<=0; state<=IDLE;
  - wb_valid<=1; wb_wd/wb_wreg<=ex_*;
  - load: wb_wdata <= extracted lane, sign-extended (LB/LH) or zero-extended (LBU/LHU);
  - store: wb_wreg<=0.
  - Minimum latency: op at cycle 0, req at cycle 1, ack at cycle 1, WB valid at cycle 2.
- mem_ack while not in WAIT is ignored.
- Timeout: if the timer reaches TIMEOUT_CYC in WAIT without ack: mem_req<=0, exc_buserr pulses, wb_valid=1, wb_wreg=0, state<=IDLE, stall released that cycle.
- Lanes for BIG_ENDIAN=1, keyed by addr[1:0]:
  - bytes: 0→sel 1000 / rdata[31:24], 1→0100, 2→0010, 3→0001;
  - halfwords: 0→1100, 2→0011;
  - word: 1111.
  - BIG_ENDIAN=0 mirrors the mapping.
- Store data: byte replicated ×4, halfword ×2.
- flush:
  - In IDLE: no request is issued and the next WB entry is invalid.
  - In WAIT: the bus transaction completes (ack or timeout) but the WB result is suppressed. Exceptions still pulse. Stores already issued remain committed.
- flush and mem_ack in the same cycle: the result is suppressed and the stage returns to IDLE.

Decomposition:
- Shared package/defines file: memop encodings, NOP reg address, ZeroWord, lane-select constants.
- Sub-module mem_lane_align (combinational): sel/wdata generation and load extract/extend, parametrised by BIG_ENDIAN.

Test Plan:
- NONE op, wd=3, wdata=0x1234 → next cycle wb_valid=1, wb_wd=3, wb_wdata=0x1234, mem_req never asserted.
- LB addr 0x101, rdata=0x11F2_3344, ack after 3 cycles → mem_addr=0x100, sel=0100, stall_req held 3 cycles, wb_wdata=0xFFFF_FFF2. LBU with the same stimulus → 0x0000_00F2.
- SH addr 0x202, sdata=0xABCD → mem_we=1, sel=0011, mem_wdata=0xABCD_ABCD, wb_wreg=0 after ack.
- LW addr 0x102 → exc_align pulse, mem_req stays 0, wb_wreg=0, no stall.
- LW with no ack, TIMEOUT_CYC=4 → req drops after 4 WAIT cycles, exc_buserr pulse, stall released. Repeat with rst asserted at WAIT cycle 2 → all outputs 0 next cycle.
- Load in WAIT, flush asserted, ack 2 cycles later → req held until ack, wb_valid=0. Back-to-back LW/LW with same-cycle ack → second req on the cycle after the first ack.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings, size classes,
// the NOP register address, the all-zero word, byte-lane select constants,
// the FSM state type and small decode helpers used by the stage and its
// lane aligner.
package mem_access_stage_pkg;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LBU  = 4'd2,
    MOP_LH   = 4'd3,
    MOP_LHU  = 4'd4,
    MOP_LW   = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } memop_e;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  localparam logic [4:0]  NOP_REG   = '0;
  localparam logic [31:0] ZERO_WORD = '0;

  // Lane enables relative to lane 0 (bits [7:0]); shifted by the lane index.
  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Unused encodings collapse onto NONE.
  function automatic memop_e decode_memop(input logic [3:0] raw);
    memop_e op;
    case (raw)
      4'd1:    op = MOP_LB;
      4'd2:    op = MOP_LBU;
      4'd3:    op = MOP_LH;
      4'd4:    op = MOP_LHU;
      4'd5:    op = MOP_LW;
      4'd6:    op = MOP_SB;
      4'd7:    op = MOP_SH;
      4'd8:    op = MOP_SW;
      default: op = MOP_NONE;
    endcase
    return op;
  endfunction

  function automatic size_e memop_size(input memop_e op);
    size_e sz;
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: sz = SZ_BYTE;
      MOP_LH, MOP_LHU, MOP_SH: sz = SZ_HALF;
      MOP_LW, MOP_SW:          sz = SZ_WORD;
      default:                 sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic memop_is_load(input memop_e op);
    return (op == MOP_LB) || (op == MOP_LBU) || (op == MOP_LH) ||
           (op == MOP_LHU) || (op == MOP_LW);
  endfunction

  function automatic logic memop_is_store(input memop_e op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

  function automatic logic memop_is_signed(input memop_e op);
    return (op == MOP_LB) || (op == MOP_LH);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Single-outstanding req/ack data bus between the MEM stage (master) and
// the data memory (slave).
//   mem_req   master->slave  request, held until mem_ack
//   mem_we    master->slave  write
//   mem_addr  master->slave  word-aligned address
//   mem_sel   master->slave  byte-lane enables
//   mem_wdata master->slave  lane-replicated store data
//   mem_ack   slave->master  transaction complete, rdata valid same cycle
//   mem_rdata slave->master  read data
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_sel;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for the MEM stage.
// Store side: lane enables, lane-replicated write data and misalignment flag
// for the op presented by EX.
// Load side: picks the addressed lane out of the read word and sign- or
// zero-extends it.
//   st_op_i/st_addr_i/st_data_i  store-side op, address low bits, data
//   sel_o/wdata_o/misalign_o     lane enables, bus data, misaligned access
//   ld_op_i/ld_addr_i/rdata_i    load-side op, address low bits, bus data
//   ld_data_o                    extended load result
module mem_lane_align
  import mem_access_stage_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  memop_e      st_op_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  input  memop_e      ld_op_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  size_e       st_size;
  size_e       ld_size;
  logic [1:0]  st_lane;
  logic [1:0]  ld_lane;
  logic [31:0] ld_shift;
  logic        ld_sign;

  // Lane index of the least-significant byte of the access. Big-endian puts
  // the lowest address in the top lane, hence the mirrored offset.
  always_comb begin
    st_size    = memop_size(st_op_i);
    st_lane    = 2'd0;
    sel_o      = SEL_NONE;
    wdata_o    = ZERO_WORD;
    misalign_o = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        st_lane = BIG_ENDIAN ? (2'd3 - st_addr_i) : st_addr_i;
        sel_o   = SEL_BYTE << st_lane;
        wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_lane    = BIG_ENDIAN ? (2'd2 - st_addr_i) : st_addr_i;
        sel_o      = SEL_HALF << st_lane;
        wdata_o    = {2{st_data_i[15:0]}};
        misalign_o = st_addr_i[0];
      end
      SZ_WORD: begin
        sel_o      = SEL_WORD;
        wdata_o    = st_data_i;
        misalign_o = |st_addr_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_size = memop_size(ld_op_i);
    ld_sign = memop_is_signed(ld_op_i);
    case (ld_size)
      SZ_BYTE: ld_lane = BIG_ENDIAN ? (2'd3 - ld_addr_i) : ld_addr_i;
      SZ_HALF: ld_lane = BIG_ENDIAN ? (2'd2 - ld_addr_i) : ld_addr_i;
      default: ld_lane = 2'd0;
    endcase
    ld_shift = rdata_i >> {ld_lane, 3'b000};
    case (ld_size)
      SZ_BYTE: ld_data_o = {{24{ld_sign & ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data_o = {{16{ld_sign & ld_shift[15]}}, ld_shift[15:0]};
      SZ_WORD: ld_data_o = ld_shift;
      default: ld_data_o = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage with the MEM/WB register folded in. Executes byte,
// halfword and word loads/stores on a single-outstanding req/ack bus,
// aligns and extends load data, raises stall_req while a transaction is
// pending, and reports misaligned accesses and bus timeouts as pulses.
//   clk, rst            clock, synchronous active-high reset
//   flush               discard the current/pending op result
//   ex_*                op from EX (held stable while stall_req is high)
//   stall_req           combinational stall to pipeline control
//   bus                 data bus, master side
//   wb_*                registered WB entry
//   exc_align           one-cycle pulse, misaligned access
//   exc_buserr          one-cycle pulse, bus timeout
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [31:0]           ex_wdata,
  input  logic [3:0]            ex_memop,
  input  logic [ADDR_W-1:0]     ex_addr,
  input  logic [31:0]           ex_sdata,
  output logic                  stall_req,
  mem_access_stage_if.master    bus,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [31:0]           wb_wdata,
  output logic                  exc_align,
  output logic                  exc_buserr
);

  localparam int unsigned TW      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [TW-1:0] TO_LAST_T = TW'(TO_LAST);

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [3:0]            mem_sel_q, mem_sel_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_wd_q, wb_wd_d;
  logic                  wb_wreg_q, wb_wreg_d;
  logic [31:0]           wb_wdata_q, wb_wdata_d;
  logic                  exc_align_q, exc_align_d;
  logic                  exc_buserr_q, exc_buserr_d;
  // Op context captured at issue so completion does not depend on EX.
  memop_e                op_q, op_d;
  logic [1:0]            alo_q, alo_d;
  logic [REG_ADDR_W-1:0] wd_q, wd_d;
  logic                  wreg_q, wreg_d;
  logic                  flushed_q, flushed_d;

  memop_e      ex_op;
  logic [3:0]  st_sel;
  logic [31:0] st_wdata;
  logic        st_misalign;
  logic [31:0] ld_data;
  logic        timeout_hit;

  assign ex_op = decode_memop(ex_memop);

  mem_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .st_op_i   (ex_op),
    .st_addr_i (ex_addr[1:0]),
    .st_data_i (ex_sdata),
    .sel_o     (st_sel),
    .wdata_o   (st_wdata),
    .misalign_o(st_misalign),
    .ld_op_i   (op_q),
    .ld_addr_i (alo_q),
    .rdata_i   (bus.mem_rdata),
    .ld_data_o (ld_data)
  );

  // Timer counts completed WAIT cycles; the last allowed cycle is the one
  // in which it equals TIMEOUT_CYC-1, so the request is up for exactly
  // TIMEOUT_CYC cycles.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TO_LAST_T);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_sel_d    = mem_sel_q;
    mem_wdata_d  = mem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_wd_d      = wb_wd_q;
    wb_wreg_d    = wb_wreg_q;
    wb_wdata_d   = wb_wdata_q;
    exc_align_d  = 1'b0;
    exc_buserr_d = 1'b0;
    op_d         = op_q;
    alo_d        = alo_q;
    wd_d         = wd_q;
    wreg_d       = wreg_q;
    flushed_d    = flushed_q;
    stall_req    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid && !flush) begin
          if (ex_op == MOP_NONE) begin
            wb_valid_d = 1'b1;
            wb_wd_d    = ex_wd;
            wb_wreg_d  = ex_wreg;
            wb_wdata_d = ex_wdata;
          end else if (st_misalign) begin
            exc_align_d = 1'b1;
            wb_valid_d  = 1'b1;
            wb_wd_d     = ex_wd;
            wb_wreg_d   = 1'b0;
            wb_wdata_d  = ZERO_WORD;
          end else begin
            stall_req   = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = memop_is_store(ex_op);
            mem_addr_d  = {ex_addr[ADDR_W-1:2], 2'b00};
            mem_sel_d   = st_sel;
            mem_wdata_d = st_wdata;
            state_d     = ST_WAIT;
            timer_d     = '0;
            op_d        = ex_op;
            alo_d       = ex_addr[1:0];
            wd_d        = ex_wd;
            wreg_d      = ex_wreg;
            flushed_d   = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_ack || timeout_hit) begin
          mem_req_d  = 1'b0;
          state_d    = ST_IDLE;
          // A flush seen at any point in WAIT, including this cycle,
          // suppresses the WB entry; the bus side still completes.
          wb_valid_d = !(flushed_q || flush);
          wb_wd_d    = wd_q;
          if (bus.mem_ack) begin
            wb_wreg_d  = memop_is_load(op_q) && wreg_q;
            wb_wdata_d = memop_is_load(op_q) ? ld_data : ZERO_WORD;
          end else begin
            exc_buserr_d = 1'b1;
            wb_wreg_d    = 1'b0;
            wb_wdata_d   = ZERO_WORD;
          end
        end else begin
          stall_req = 1'b1;
          timer_d   = timer_q + 1'b1;
          flushed_d = flushed_q | flush;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_sel_q    <= SEL_NONE;
      mem_wdata_q  <= ZERO_WORD;
      wb_valid_q   <= 1'b0;
      wb_wd_q      <= REG_ADDR_W'(NOP_REG);
      wb_wreg_q    <= 1'b0;
      wb_wdata_q   <= ZERO_WORD;
      exc_align_q  <= 1'b0;
      exc_buserr_q <= 1'b0;
      op_q         <= MOP_NONE;
      alo_q        <= '0;
      wd_q         <= '0;
      wreg_q       <= 1'b0;
      flushed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_sel_q    <= mem_sel_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_wd_q      <= wb_wd_d;
      wb_wreg_q    <= wb_wreg_d;
      wb_wdata_q   <= wb_wdata_d;
      exc_align_q  <= exc_align_d;
      exc_buserr_q <= exc_buserr_d;
      op_q         <= op_d;
      alo_q        <= alo_d;
      wd_q         <= wd_d;
      wreg_q       <= wreg_d;
      flushed_q    <= flushed_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_wd         = wb_wd_q;
  assign wb_wreg       = wb_wreg_q;
  assign wb_wdata      = wb_wdata_q;
  assign exc_align     = exc_align_q;
  assign exc_buserr    = exc_buserr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized checks of mem_access_stage against a byte-addressed
// big-endian memory model.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic [3:0]  ex_memop = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_sdata = '0;
  logic        stall_req;
  logic        wb_valid;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        exc_align;
  logic        exc_buserr;

  mem_access_stage_if #(.ADDR_W(32)) bus();

  mem_access_stage #(
    .ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(TO), .BIG_ENDIAN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_memop(ex_memop), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
    .stall_req(stall_req), .bus(bus),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .exc_align(exc_align), .exc_buserr(exc_buserr)
  );

  always #5 clk = ~clk;

  logic [7:0]  ref_mem [0:1023];
  logic [31:0] bus_mem [0:255];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int op_size(input int op);
    case (op)
      1, 2, 6: return 1;
      3, 4, 7: return 2;
      5, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input int op, input int a);
    logic [31:0] v = '0;
    for (int i = 0; i < op_size(op); i++) v = (v << 8) | {24'h0, ref_mem[a+i]};
    if (op == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (op == 3 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // flush_at: -1 none, -2 flush in the issue cycle, k>=0 flush in WAIT cycle k.
  task automatic do_op(input int op, input int addr, input logic [31:0] sdata,
                       input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                       input int ack_delay, input int flush_at);
    int n;
    bit is_mem, is_ld, is_st, mis, flushed, done, ack, to;
    logic [3:0]  esel;
    logic [31:0] ewd, eld, tmp;
    n      = op_size(op);
    is_mem = (n > 0);
    is_ld  = (op >= 1 && op <= 5);
    is_st  = (op >= 6 && op <= 8);
    mis    = (n == 2 && (addr % 2) != 0) || (n == 4 && (addr % 4) != 0);
    ex_valid = 1'b1; ex_memop = op[3:0]; ex_addr = addr; ex_sdata = sdata;
    ex_wdata = wdata; ex_wd = wd; ex_wreg = wreg;
    flush = (flush_at == -2);
    #1;
    chk("stall_issue", stall_req, is_mem && !mis && flush_at != -2);
    tick();
    flush = 1'b0;
    if (flush_at == -2) begin
      chk("flush_idle_wbv", wb_valid, 0);
      chk("flush_idle_req", bus.mem_req, 0);
      ex_valid = 1'b0;
      return;
    end
    if (!is_mem || mis) begin
      chk("direct_wbv", wb_valid, 1);
      chk("direct_wreg", wb_wreg, is_mem ? 1'b0 : wreg);
      if (!is_mem) begin
        chk("direct_wd", wb_wd, wd);
        chk("direct_wdata", wb_wdata, wdata);
      end
      chk("exc_align", exc_align, mis);
      chk("direct_req", bus.mem_req, 0);
      ex_valid = 1'b0;
      return;
    end
    esel = '0;
    for (int i = 0; i < n; i++) esel[3 - ((addr % 4) + i)] = 1'b1;
    ewd = (n == 1) ? {4{sdata[7:0]}} : (n == 2) ? {2{sdata[15:0]}} : sdata;
    chk("issue_req", bus.mem_req, 1);
    chk("issue_we", bus.mem_we, is_st);
    chk("issue_addr", bus.mem_addr, addr & ~3);
    chk("issue_sel", bus.mem_sel, esel);
    if (is_st) chk("issue_wdata", bus.mem_wdata, ewd);
    chk("issue_wbv", wb_valid, 0);
    eld = ref_load(op, addr);
    if (is_st) begin
      for (int i = 0; i < n; i++) begin
        tmp = sdata >> (8 * (n - 1 - i));
        ref_mem[addr+i] = tmp[7:0];
      end
    end
    flushed = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      ack = (c == ack_delay);
      to  = !ack && (c == TO - 1);
      flush = (c == flush_at);
      if (flush) flushed = 1;
      bus.mem_ack   = ack;
      bus.mem_rdata = (ack && is_ld) ? bus_mem[addr/4] : $urandom();
      if (ack && is_st)
        for (int l = 0; l < 4; l++)
          if (bus.mem_sel[l]) bus_mem[bus.mem_addr[9:2]][8*l +: 8] = bus.mem_wdata[8*l +: 8];
      #1;
      chk("stall_wait", stall_req, !(ack || to));
      tick();
      bus.mem_ack = 1'b0;
      flush = 1'b0;
      if (ack || to) begin
        done = 1;
        chk("done_req", bus.mem_req, 0);
        chk("done_wbv", wb_valid, !flushed);
        chk("done_buserr", exc_buserr, to);
        if (!flushed) begin
          chk("done_wreg", wb_wreg, (is_ld && !to) ? wreg : 1'b0);
          if (!to) chk("done_wd", wb_wd, wd);
          if (is_ld && !to && wreg) chk("done_ldata", wb_wdata, eld);
        end
      end else begin
        chk("hold_req", bus.mem_req, 1);
        chk("hold_addr", bus.mem_addr, addr & ~3);
      end
    end
    chk("wait_bound", done, 1);
    ex_valid = 1'b0;
  endtask

  initial begin
    int op, addr, dly, fa;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    for (int b = 0; b < 1024; b++) ref_mem[b] = 8'($urandom());
    ref_mem[256] = 8'h11; ref_mem[257] = 8'hF2; ref_mem[258] = 8'h33; ref_mem[259] = 8'h44;
    for (int w = 0; w < 256; w++)
      bus_mem[w] = {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]};

    // Reset state
    tick(); tick();
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_sel", bus.mem_sel, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wd", wb_wd, 0);
    chk("rst_stall", stall_req, 0);
    rst = 1'b0;
    tick();

    // NONE op passes straight through
    do_op(0, 0, 0, 32'h1234, 5'd3, 1'b1, 0, -1);
    tick();
    chk("none_bubble_wbv", wb_valid, 0);

    // LB / LBU at 0x101 against word 0x11F23344
    do_op(1, 'h101, 0, 0, 5'd5, 1'b1, 2, -1);
    chk("lb_const", wb_wdata, 32'hFFFF_FFF2);
    do_op(2, 'h101, 0, 0, 5'd6, 1'b1, 2, -1);
    chk("lbu_const", wb_wdata, 32'h0000_00F2);

    // SH 0x202
    do_op(7, 'h202, 32'h0000_ABCD, 0, 5'd7, 1'b1, 1, -1);
    chk("sh_sel_const", bus.mem_sel, 4'b0011);
    chk("sh_wdata_const", bus.mem_wdata, 32'hABCD_ABCD);

    // Misaligned LW, then pulse must clear
    do_op(5, 'h102, 0, 0, 5'd8, 1'b1, 0, -1);
    tick();
    chk("align_pulse_end", exc_align, 0);

    // Timeout
    do_op(5, 'h10, 0, 0, 5'd9, 1'b1, 99, -1);
    tick();
    chk("buserr_pulse_end", exc_buserr, 0);

    // Reset in WAIT cycle 2
    ex_valid = 1'b1; ex_memop = 4'd5; ex_addr = 'h40; ex_wd = 5'd10; ex_wreg = 1'b1;
    tick(); tick();
    rst = 1'b1; ex_valid = 1'b0;
    tick();
    chk("mrst_req", bus.mem_req, 0);
    chk("mrst_we", bus.mem_we, 0);
    chk("mrst_addr", bus.mem_addr, 0);
    chk("mrst_sel", bus.mem_sel, 0);
    chk("mrst_wbv", wb_valid, 0);
    chk("mrst_wreg", wb_wreg, 0);
    chk("mrst_buserr", exc_buserr, 0);
    chk("mrst_stall", stall_req, 0);
    rst = 1'b0;
    tick();

    // Flush during WAIT, and flush together with ack
    do_op(5, 'h20, 0, 0, 5'd11, 1'b1, 2, 0);
    do_op(1, 'h23, 0, 0, 5'd12, 1'b1, 1, 1);

    // Back-to-back LW with immediate ack
    do_op(5, 'h30, 0, 0, 5'd13, 1'b1, 0, -1);
    do_op(5, 'h34, 0, 0, 5'd14, 1'b1, 0, -1);

    // Flush in IDLE; stray ack in IDLE
    do_op(5, 'h8, 0, 0, 5'd15, 1'b1, 0, -2);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("stray_ack_wbv", wb_valid, 0);
    chk("stray_ack_req", bus.mem_req, 0);

    // Randomized ops
    for (int k = 0; k < 200; k++) begin
      op = $urandom_range(0, 10);
      addr = $urandom_range(0, 1019);
      if ($urandom_range(0, 2) != 0) addr = addr & ~3;
      if (op >= 6 && op <= 8) dly = $urandom_range(0, 2);
      else dly = $urandom_range(0, 5);
      fa = -1;
      if ($urandom_range(0, 7) == 0) fa = $urandom_range(0, 3);
      else if ($urandom_range(0, 15) == 0) fa = -2;
      do_op(op, addr, $urandom(), $urandom(), 5'($urandom()), 1'($urandom()), dly, fa);
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk("gap_wbv", wb_valid, 0);
        chk("gap_align", exc_align, 0);
        chk("gap_buserr", exc_buserr, 0);
      end
    end

    // Committed stores match the byte model
    for (int w = 0; w < 256; w++)
      chk("mem_word", bus_mem[w],
          {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
